// File: rtl/pin_lockout_controller.sv
// Keypad PIN checker that unlocks until relock and locks out after repeated failures.
// Define PIN_ENTRY_TIMEOUT_EN to discard a partial entry after ENTRY_TIMEOUT_CYCLES idle cycles.
module pin_lockout_controller #(
   parameter int DIGITS               = 4,
   parameter int MAX_ATTEMPTS         = 3,
   parameter int LOCKOUT_CYCLES       = 1000,
   parameter int ENTRY_TIMEOUT_CYCLES = 500
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic [3:0]                          key,
   input  logic [4*DIGITS-1:0]                 pinCode,
   input  logic                                relock,
   output logic                                unlock,
   output logic                                lockedOut,
   output logic                                error,
   output logic [4*DIGITS-1:0]                 pinEntry,
   output logic [$clog2(DIGITS+1)-1:0]         digitCount,
   output logic [$clog2(MAX_ATTEMPTS+1)-1:0]   failCount
);
   localparam int DCW = $clog2(DIGITS+1);
   localparam int FCW = $clog2(MAX_ATTEMPTS+1);
   localparam int LCW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
   localparam logic [DCW-1:0] DIGITS_LAST = DCW'(DIGITS-1);
   localparam logic [FCW-1:0] FAIL_LAST   = FCW'(MAX_ATTEMPTS-1);
   localparam logic [LCW-1:0] LOCK_LAST   = LCW'(LOCKOUT_CYCLES-1);

   typedef enum logic [1:0] {ENTRY, CHECK, UNLOCKED, LOCKOUT} state_t;

   state_t              state_reg, state_next;
   logic [3:0]          key_prev_reg;
   logic [4*DIGITS-1:0] pin_entry_reg, pin_entry_next;
   logic [DCW-1:0]      digit_count_reg, digit_count_next;
   logic [FCW-1:0]      fail_count_reg, fail_count_next;
   logic [LCW-1:0]      lock_count_reg, lock_count_next;
   logic                error_reg, error_next;
   logic                unlock_reg, locked_out_reg;
   logic                press;
   logic [4*DIGITS-1:0] entry_shifted;
   logic [DIGITS-1:0]   digit_match;
   logic                code_match;

   // Only a rising edge out of the all-released state counts as a press
   assign press = (key_prev_reg == 4'b0000) && (key != 4'b0000);

   generate
      if (DIGITS == 1) begin : g_shift_single
         assign entry_shifted = key;
      end else begin : g_shift_multi
         assign entry_shifted = {pin_entry_reg[4*DIGITS-5:0], key};
      end
   endgenerate

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit_cmp
         assign digit_match[gi] = (pin_entry_reg[4*gi +: 4] == pinCode[4*gi +: 4]);
      end
   endgenerate
   assign code_match = &digit_match;

`ifdef PIN_ENTRY_TIMEOUT_EN
   localparam int ICW = $clog2(ENTRY_TIMEOUT_CYCLES+1);
   localparam logic [ICW-1:0] IDLE_LAST = ICW'(ENTRY_TIMEOUT_CYCLES-1);
   logic [ICW-1:0] idle_count_reg, idle_count_next;
`endif

   always_comb begin
      state_next       = state_reg;
      pin_entry_next   = pin_entry_reg;
      digit_count_next = digit_count_reg;
      fail_count_next  = fail_count_reg;
      lock_count_next  = '0;
      error_next       = 1'b0;
`ifdef PIN_ENTRY_TIMEOUT_EN
      idle_count_next  = '0;
`endif
      case (state_reg)
         ENTRY: begin
            if (press) begin
               pin_entry_next   = entry_shifted;
               digit_count_next = digit_count_reg + 1'b1;
               if (digit_count_reg == DIGITS_LAST) begin
                  state_next = CHECK;
               end
            end
`ifdef PIN_ENTRY_TIMEOUT_EN
            else if (digit_count_reg != '0) begin
               if (idle_count_reg == IDLE_LAST) begin
                  pin_entry_next   = '0;
                  digit_count_next = '0;
               end else begin
                  idle_count_next = idle_count_reg + 1'b1;
               end
            end
`endif
         end
         CHECK: begin
            pin_entry_next   = '0;
            digit_count_next = '0;
            if (code_match) begin
               state_next      = UNLOCKED;
               fail_count_next = '0;
            end else begin
               error_next      = 1'b1;
               fail_count_next = fail_count_reg + 1'b1;
               state_next      = (fail_count_reg == FAIL_LAST) ? LOCKOUT : ENTRY;
            end
         end
         UNLOCKED: begin
            if (relock) begin
               state_next = ENTRY;
            end
         end
         LOCKOUT: begin
            if (lock_count_reg == LOCK_LAST) begin
               state_next      = ENTRY;
               fail_count_next = '0;
            end else begin
               lock_count_next = lock_count_reg + 1'b1;
            end
         end
         default: state_next = ENTRY;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg       <= ENTRY;
         key_prev_reg    <= 4'b0000;
         pin_entry_reg   <= '0;
         digit_count_reg <= '0;
         fail_count_reg  <= '0;
         lock_count_reg  <= '0;
         error_reg       <= 1'b0;
         unlock_reg      <= 1'b0;
         locked_out_reg  <= 1'b0;
`ifdef PIN_ENTRY_TIMEOUT_EN
         idle_count_reg  <= '0;
`endif
      end else begin
         state_reg       <= state_next;
         key_prev_reg    <= key;
         pin_entry_reg   <= pin_entry_next;
         digit_count_reg <= digit_count_next;
         fail_count_reg  <= fail_count_next;
         lock_count_reg  <= lock_count_next;
         error_reg       <= error_next;
         unlock_reg      <= (state_next == UNLOCKED);
         locked_out_reg  <= (state_next == LOCKOUT);
`ifdef PIN_ENTRY_TIMEOUT_EN
         idle_count_reg  <= idle_count_next;
`endif
      end
   end

   assign unlock     = unlock_reg;
   assign lockedOut  = locked_out_reg;
   assign error      = error_reg;
   assign pinEntry   = pin_entry_reg;
   assign digitCount = digit_count_reg;
   assign failCount  = fail_count_reg;

endmodule

// File: tb/tb_pin_lockout_controller.sv
// Directed bench for pin_lockout_controller: DIGITS=4, MAX_ATTEMPTS=3, LOCKOUT_CYCLES=20, code 1248.
module tb_pin_lockout_controller;
   logic        clock;
   logic        reset;
   logic [3:0]  key;
   logic [15:0] pinCode;
   logic        relock;
   logic        unlock;
   logic        lockedOut;
   logic        error;
   logic [15:0] pinEntry;
   logic [2:0]  digitCount;
   logic [1:0]  failCount;

   int total = 0;
   int bad   = 0;

   pin_lockout_controller #(
      .DIGITS(4),
      .MAX_ATTEMPTS(3),
      .LOCKOUT_CYCLES(20),
      .ENTRY_TIMEOUT_CYCLES(8)
   ) dut (
      .clock(clock),
      .reset(reset),
      .key(key),
      .pinCode(pinCode),
      .relock(relock),
      .unlock(unlock),
      .lockedOut(lockedOut),
      .error(error),
      .pinEntry(pinEntry),
      .digitCount(digitCount),
      .failCount(failCount)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic press_release(input logic [3:0] d);
      key = d;
      tick();
      key = 4'b0000;
      tick();
   endtask

   task automatic enter_code(input logic [15:0] code);
      for (int i = 3; i >= 0; i--) press_release(code[4*i +: 4]);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      total++;
      if ({unlock, lockedOut, error, pinEntry, digitCount, failCount} !== 24'h0) begin
         bad++;
         $display("FAIL reset_state: got u=%0b lo=%0b e=%0b pe=%h dc=%0d fc=%0d want all zero",
                  unlock, lockedOut, error, pinEntry, digitCount, failCount);
      end
      $display("test_reset: outputs after reset pe=%h dc=%0d", pinEntry, digitCount);
   endtask

   task automatic test_correct_entry();
      press_release(4'h1);
      press_release(4'h2);
      press_release(4'h4);
      key = 4'h8;
      tick();
      total++;
      if (pinEntry !== 16'h1248 || digitCount !== 3'd4) begin
         bad++;
         $display("FAIL correct_entry_digits: got pe=%h dc=%0d want pe=1248 dc=4", pinEntry, digitCount);
      end
      total++;
      if (unlock !== 1'b0) begin
         bad++;
         $display("FAIL correct_check_cycle: got unlock=%0b want 0", unlock);
      end
      key = 4'h0;
      tick();
      total++;
      if (unlock !== 1'b1 || error !== 1'b0 || failCount !== 2'd0 || pinEntry !== 16'h0) begin
         bad++;
         $display("FAIL correct_unlock: got u=%0b e=%0b fc=%0d pe=%h want u=1 e=0 fc=0 pe=0",
                  unlock, error, failCount, pinEntry);
      end
      relock = 1'b1;
      tick();
      relock = 1'b0;
      total++;
      if (unlock !== 1'b0 || digitCount !== 3'd0) begin
         bad++;
         $display("FAIL relock: got u=%0b dc=%0d want u=0 dc=0", unlock, digitCount);
      end
      $display("test_correct_entry: unlock then relock done");
   endtask

   task automatic test_wrong_entry();
      enter_code(16'h1244);
      total++;
      if (error !== 1'b1 || failCount !== 2'd1 || pinEntry !== 16'h0 || unlock !== 1'b0) begin
         bad++;
         $display("FAIL wrong_entry: got e=%0b fc=%0d pe=%h u=%0b want e=1 fc=1 pe=0 u=0",
                  error, failCount, pinEntry, unlock);
      end
      tick();
      total++;
      if (error !== 1'b0 || unlock !== 1'b0) begin
         bad++;
         $display("FAIL wrong_error_width: got e=%0b u=%0b want e=0 u=0", error, unlock);
      end
      $display("test_wrong_entry: failCount=%0d", failCount);
   endtask

   task automatic test_lockout();
      int cnt;
      enter_code(16'h4444);
      enter_code(16'h8421);
      total++;
      if (lockedOut !== 1'b1 || failCount !== 2'd3 || error !== 1'b1) begin
         bad++;
         $display("FAIL lockout_entry: got lo=%0b fc=%0d e=%0b want lo=1 fc=3 e=1", lockedOut, failCount, error);
      end
      cnt = 0;
      while (lockedOut === 1'b1 && cnt < 100) begin
         cnt++;
         key = (cnt >= 5 && cnt < 8) ? 4'h1 : 4'h0;
         if (cnt == 12) key = 4'h2;
         tick();
      end
      key = 4'h0;
      total++;
      if (cnt != 20) begin
         bad++;
         $display("FAIL lockout_duration: got %0d cycles want 20", cnt);
      end
      total++;
      if (pinEntry !== 16'h0 || digitCount !== 3'd0 || failCount !== 2'd0) begin
         bad++;
         $display("FAIL lockout_exit: got pe=%h dc=%0d fc=%0d want pe=0 dc=0 fc=0", pinEntry, digitCount, failCount);
      end
      tick();
      enter_code(16'h1248);
      total++;
      if (unlock !== 1'b1 || failCount !== 2'd0) begin
         bad++;
         $display("FAIL lockout_recover: got u=%0b fc=%0d want u=1 fc=0", unlock, failCount);
      end
      relock = 1'b1;
      tick();
      relock = 1'b0;
      $display("test_lockout: lockedOut lasted %0d cycles", cnt);
   endtask

   task automatic test_key_hygiene();
      key = 4'h1;
      repeat (10) tick();
      key = 4'h0;
      tick();
      total++;
      if (digitCount !== 3'd1 || pinEntry !== 16'h0001) begin
         bad++;
         $display("FAIL held_key: got dc=%0d pe=%h want dc=1 pe=0001", digitCount, pinEntry);
      end
      key = 4'h1;
      tick();
      key = 4'h3;
      tick();
      total++;
      if (digitCount !== 3'd2 || pinEntry !== 16'h0011) begin
         bad++;
         $display("FAIL key_change: got dc=%0d pe=%h want dc=2 pe=0011", digitCount, pinEntry);
      end
      key = 4'h0;
      tick();
      key = 4'h5;
      tick();
      total++;
      if (digitCount !== 3'd3 || pinEntry !== 16'h0115) begin
         bad++;
         $display("FAIL multi_bit_digit: got dc=%0d pe=%h want dc=3 pe=0115", digitCount, pinEntry);
      end
      key = 4'h0;
      tick();
      press_release(4'h1);
      total++;
      if (error !== 1'b1 || failCount !== 2'd1) begin
         bad++;
         $display("FAIL hygiene_check: got e=%0b fc=%0d want e=1 fc=1", error, failCount);
      end
      $display("test_key_hygiene: captured 1151 as a failed attempt");
   endtask

   task automatic test_reset_mid_op();
      enter_code(16'h2222);
      press_release(4'h1);
      press_release(4'h2);
      total++;
      if (failCount !== 2'd2 || digitCount !== 3'd2 || pinEntry !== 16'h0012) begin
         bad++;
         $display("FAIL pre_reset: got fc=%0d dc=%0d pe=%h want fc=2 dc=2 pe=0012", failCount, digitCount, pinEntry);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total++;
      if ({unlock, lockedOut, error, pinEntry, digitCount, failCount} !== 24'h0) begin
         bad++;
         $display("FAIL mid_reset: got u=%0b lo=%0b e=%0b pe=%h dc=%0d fc=%0d want all zero",
                  unlock, lockedOut, error, pinEntry, digitCount, failCount);
      end
      enter_code(16'h1248);
      total++;
      if (unlock !== 1'b1 || failCount !== 2'd0) begin
         bad++;
         $display("FAIL post_reset_unlock: got u=%0b fc=%0d want u=1 fc=0", unlock, failCount);
      end
      relock = 1'b1;
      tick();
      relock = 1'b0;
      $display("test_reset_mid_op: unlock after reset u=%0b", unlock);
   endtask

   task automatic test_entry_timeout();
      int err_seen;
      err_seen = 0;
      press_release(4'h1);
      press_release(4'h2);
      for (int i = 0; i < 6; i++) begin
         if (error !== 1'b0) err_seen++;
         tick();
      end
      total++;
      if (digitCount !== 3'd2 || pinEntry !== 16'h0012) begin
         bad++;
         $display("FAIL timeout_before: got dc=%0d pe=%h want dc=2 pe=0012", digitCount, pinEntry);
      end
      tick();
`ifdef PIN_ENTRY_TIMEOUT_EN
      total++;
      if (digitCount !== 3'd0 || pinEntry !== 16'h0) begin
         bad++;
         $display("FAIL timeout_clear: got dc=%0d pe=%h want dc=0 pe=0", digitCount, pinEntry);
      end
`else
      total++;
      if (digitCount !== 3'd2 || pinEntry !== 16'h0012) begin
         bad++;
         $display("FAIL no_timeout: got dc=%0d pe=%h want dc=2 pe=0012", digitCount, pinEntry);
      end
`endif
      if (error !== 1'b0) err_seen++;
      total++;
      if (err_seen != 0 || failCount !== 2'd0) begin
         bad++;
         $display("FAIL timeout_side_effects: got err_seen=%0d fc=%0d want 0 0", err_seen, failCount);
      end
      $display("test_entry_timeout: digitCount=%0d after idle", digitCount);
   endtask

   initial begin
      reset   = 1'b1;
      key     = 4'h0;
      relock  = 1'b0;
      pinCode = 16'h1248;
      test_reset();
      test_correct_entry();
      test_wrong_entry();
      test_lockout();
      test_key_hygiene();
      test_reset_mid_op();
      test_entry_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
